// File: rtl/data_memory_pkg.sv
// Shared state encoding, memory-port widths and address helper for data_memory_bridge.
package data_memory_pkg;

  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dmb_state_e;

  // Word-to-byte address shift: log2 of the CPU word size in bytes.
  function automatic int byte_shift(input int data_width);
    if (data_width > 16) return 2;
    else if (data_width > 8) return 1;
    else return 0;
  endfunction

endpackage

// File: rtl/dmb_timeout_counter.sv
// WAIT-state watchdog for data_memory_bridge; the module exists only when
// DMB_TIMEOUT_EN is defined.
`ifdef DMB_TIMEOUT_EN
module dmb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] r_count;

  // Saturates at the limit so a stalled bridge never wraps back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == LIMIT);

endmodule
`endif

// File: rtl/data_memory_bridge.sv
// Bridges one-cycle CPU load/store requests onto a level-held 32-bit memory
// request closed by mem_response. Define DMB_TIMEOUT_EN for the WAIT watchdog.
module data_memory_bridge
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr,
  input  logic                      cpu_read_en,
  input  logic                      cpu_write_en,
  input  logic [DATA_WIDTH-1:0]     cpu_write_data,
  input  logic [DATA_WIDTH/8-1:0]   cpu_byte_en,
  output logic [DATA_WIDTH-1:0]     cpu_read_data,
  output logic                      cpu_busy,
  output logic                      cpu_done,
  output logic                      cpu_error,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_read_en,
  output logic                      mem_write_en,
  output logic [MEM_DATA_WIDTH-1:0] mem_write_val,
  output logic [3:0]                mem_byte_en,
  input  logic [MEM_DATA_WIDTH-1:0] mem_read_val,
  input  logic                      mem_response
);

  localparam int BYTE_SHIFT = byte_shift(DATA_WIDTH);

  dmb_state_e                r_state;
  dmb_state_e                w_next_state;
  logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
  logic [MEM_DATA_WIDTH-1:0] r_mem_write_val;
  logic [3:0]                r_mem_byte_en;
  logic                      r_mem_read_en;
  logic                      r_mem_write_en;
  logic                      r_is_write;
  logic [DATA_WIDTH-1:0]     r_read_data;
  logic                      r_error;
  logic                      w_accept;
  logic                      w_complete;
  logic                      w_timeout;

  // A write beats a simultaneous read; requests outside IDLE are dropped.
  assign w_accept   = (r_state == IDLE) && (cpu_write_en || cpu_read_en);
  assign w_complete = (r_state == WAIT) && mem_response;

`ifdef DMB_TIMEOUT_EN
  logic w_cnt_clear;
  logic w_cnt_run;
  logic w_expired;

  assign w_cnt_clear = (r_state == REQ);
  assign w_cnt_run   = (r_state == WAIT);

  dmb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_cnt_clear),
    .run    (w_cnt_run),
    .expired(w_expired)
  );

  // A response on the expiry edge completes normally.
  assign w_timeout = (r_state == WAIT) && w_expired && !mem_response;
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: the next state defaults to the current state before the case, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = REQ;
      REQ:     w_next_state = WAIT;
      WAIT:    if (w_complete || w_timeout) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments and clear asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_addr      <= '0;
      r_mem_write_val <= '0;
      r_mem_byte_en   <= '0;
      r_mem_read_en   <= 1'b0;
      r_mem_write_en  <= 1'b0;
      r_is_write      <= 1'b0;
      r_read_data     <= '0;
      r_error         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is_write <= cpu_write_en;
        r_mem_addr <= MEM_ADDR_WIDTH'(cpu_addr) << BYTE_SHIFT;
        if (cpu_write_en) begin
          r_mem_write_val <= MEM_DATA_WIDTH'(cpu_write_data);
          r_mem_byte_en   <= 4'(cpu_byte_en);
        end else begin
          r_mem_byte_en <= '0;
        end
      end

      if (r_state == REQ) begin
        r_mem_read_en  <= !r_is_write;
        r_mem_write_en <= r_is_write;
      end else if (w_complete || w_timeout) begin
        r_mem_read_en  <= 1'b0;
        r_mem_write_en <= 1'b0;
      end

      if (w_complete && !r_is_write) begin
        r_read_data <= mem_read_val[DATA_WIDTH-1:0];
      end

      r_error <= w_timeout;
    end
  end

  assign cpu_read_data = r_read_data;
  assign cpu_busy      = (r_state != IDLE);
  assign cpu_done      = (r_state == DONE);
  assign cpu_error     = r_error;
  assign mem_addr      = r_mem_addr;
  assign mem_read_en   = r_mem_read_en;
  assign mem_write_en  = r_mem_write_en;
  assign mem_write_val = r_mem_write_val;
  assign mem_byte_en   = r_mem_byte_en;

endmodule

// File: tb/tb_data_memory_bridge.sv
// Self-checking bench for data_memory_bridge: a transaction-timeline model
// predicts every output each cycle; directed cases pin literal values.
module tb_data_memory_bridge;

  localparam int TB_TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cpu_addr;
  logic        cpu_read_en, cpu_write_en;
  logic [31:0] cpu_write_data;
  logic [3:0]  cpu_byte_en;
  logic [31:0] cpu_read_data;
  logic        cpu_busy, cpu_done, cpu_error;
  logic [31:0] mem_addr;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_write_val;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_read_val;
  logic        mem_response;

  logic [7:0]  n_addr;
  logic        n_rd, n_wr;
  logic [15:0] n_wd;
  logic [1:0]  n_be;
  logic [15:0] n_rdata;
  logic        n_busy, n_done, n_err;
  logic [31:0] n_maddr;
  logic        n_mrd, n_mwr;
  logic [31:0] n_mwv;
  logic [3:0]  n_mbe;
  logic [31:0] n_mrv;
  logic        n_resp;

  always #5 clk = ~clk;

  data_memory_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_read_en(cpu_read_en),
    .cpu_write_en(cpu_write_en), .cpu_write_data(cpu_write_data), .cpu_byte_en(cpu_byte_en),
    .cpu_read_data(cpu_read_data), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
    .cpu_error(cpu_error), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_write_val(mem_write_val), .mem_byte_en(mem_byte_en),
    .mem_read_val(mem_read_val), .mem_response(mem_response)
  );

  data_memory_bridge #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(TB_TO)) u_narrow (
    .clk(clk), .reset(reset), .cpu_addr(n_addr), .cpu_read_en(n_rd),
    .cpu_write_en(n_wr), .cpu_write_data(n_wd), .cpu_byte_en(n_be),
    .cpu_read_data(n_rdata), .cpu_busy(n_busy), .cpu_done(n_done),
    .cpu_error(n_err), .mem_addr(n_maddr), .mem_read_en(n_mrd),
    .mem_write_en(n_mwr), .mem_write_val(n_mwv), .mem_byte_en(n_mbe),
    .mem_read_val(n_mrv), .mem_response(n_resp)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Timeline model: edge index of acceptance and of completion of the current transfer.
  int          k;
  int          t_acc, t_end;
  logic        m_wr, m_err;
  logic [31:0] m_addr, m_wd, m_rdata;
  logic [3:0]  m_be;
  logic        e_busy, e_done, e_err, e_rd, e_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    t_acc = -1; t_end = -1; m_wr = 1'b0; m_err = 1'b0;
    m_addr = '0; m_wd = '0; m_rdata = '0; m_be = '0;
  endtask

  task automatic compute_exp();
    e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
    if (t_acc >= 0) begin
      if (k == t_acc) begin
        e_busy = 1'b1;
      end else if (t_end < 0) begin
        e_busy = 1'b1; e_rd = !m_wr; e_wr = m_wr;
      end else if (k == t_end) begin
        e_busy = 1'b1; e_done = 1'b1; e_err = m_err;
      end
    end
  endtask

  // Drive inputs for the next edge, predict its effect, advance one cycle.
  task automatic step(input logic rd, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic resp, input logic [31:0] rval);
    cpu_read_en = rd; cpu_write_en = wr; cpu_addr = addr;
    cpu_write_data = wd; cpu_byte_en = be;
    mem_response = resp; mem_read_val = rval;
    if (!reset) begin
      if (t_acc < 0 || (t_end >= 0 && k >= t_end + 2)) begin
        if (wr || rd) begin
          t_acc = k; t_end = -1; m_wr = wr; m_err = 1'b0;
          m_addr = 32'(addr) * 4;
          m_be = wr ? be : 4'h0;
          if (wr) m_wd = wd;
        end
      end else if (t_end < 0 && k >= t_acc + 2) begin
        if (resp) begin
          t_end = k;
          if (!m_wr) m_rdata = rval;
        end
`ifdef DMB_TIMEOUT_EN
        else if (k - t_acc - 2 == TB_TO - 1) begin
          t_end = k; m_err = 1'b1;
        end
`endif
      end
    end
    compute_exp();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic step_idle();
    step(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 32'h0);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("busy", cpu_busy, e_busy);
      check("done", cpu_done, e_done);
      check("error", cpu_error, e_err);
      check("mem_read_en", mem_read_en, e_rd);
      check("mem_write_en", mem_write_en, e_wr);
      check("read_data", cpu_read_data, m_rdata);
      if (e_rd || e_wr) begin
        check("mem_addr", mem_addr, m_addr);
        check("mem_byte_en", mem_byte_en, m_be);
      end
      if (e_wr) check("mem_write_val", mem_write_val, m_wd);
    end
  end

  initial begin
    int hi;
    logic [31:0] saved;
    reset = 1'b1; k = 0;
    cpu_addr = '0; cpu_read_en = 0; cpu_write_en = 0; cpu_write_data = '0; cpu_byte_en = '0;
    mem_read_val = '0; mem_response = 0;
    n_addr = '0; n_rd = 0; n_wr = 0; n_wd = '0; n_be = '0; n_mrv = '0; n_resp = 0;
    model_reset();
    compute_exp();
    repeat (2) @(negedge clk);
    check("rst_busy", cpu_busy, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_read_data", cpu_read_data, 0);
    check("rst_enables", {mem_read_en, mem_write_en, cpu_done, cpu_error}, 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Read at word 0x05, memory answers two cycles after the enable appears.
    step(1, 0, 8'h05, 32'h0, 4'h0, 0, 32'h0);
    step_idle();
    check("rd_en_up", mem_read_en, 1);
    check("rd_addr", mem_addr, 32'h14);
    step_idle();
    step(0, 0, 8'h00, 32'h0, 4'h0, 1, 32'hDEADBEEF);
    check("rd_done", cpu_done, 1);
    check("rd_data", cpu_read_data, 32'hDEADBEEF);
    step_idle();
    check("rd_done_once", cpu_done, 0);

    // Byte-enabled write held until the response.
    step(0, 1, 8'h03, 32'hA5A5_0F0F, 4'b0110, 0, 32'h0);
    step_idle();
    check("wr_en", mem_write_en, 1);
    check("wr_addr", mem_addr, 32'h0C);
    check("wr_be", mem_byte_en, 4'b0110);
    check("wr_val", mem_write_val, 32'hA5A5_0F0F);
    step_idle();
    check("wr_en_held", mem_write_en, 1);
    step(0, 0, 8'h00, 32'h0, 4'h0, 1, 32'h5555_5555);
    check("wr_done", cpu_done, 1);
    check("wr_keeps_rdata", cpu_read_data, 32'hDEADBEEF);
    step_idle();

    // Simultaneous read/write, requests while busy, request during and after DONE.
    step(1, 1, 8'h10, 32'h1111_2222, 4'hF, 0, 32'h0);
    step_idle();
    check("sim_wr", mem_write_en, 1);
    check("sim_rd", mem_read_en, 0);
    step(1, 0, 8'h3F, 32'h0, 4'h0, 0, 32'h0);
    check("busy_ignored_addr", mem_addr, 32'h40);
    step(0, 0, 8'h00, 32'h0, 4'h0, 1, 32'h0);
    check("sim_done", cpu_done, 1);
    step(1, 0, 8'h33, 32'h0, 4'h0, 1, 32'h0);
    check("done_cycle_req_ignored", cpu_busy, 0);
    step(1, 0, 8'h22, 32'h0, 4'h0, 0, 32'h0);
    check("after_done_accept", cpu_busy, 1);
    step_idle();
    check("b2b_addr", mem_addr, 32'h88);
    step(0, 0, 8'h00, 32'h0, 4'h0, 1, 32'h0BAD_F00D);
    check("b2b_data", cpu_read_data, 32'h0BAD_F00D);
    step_idle();

`ifdef DMB_TIMEOUT_EN
    // No response: abort after TB_TO WAIT cycles with an error pulse.
    saved = cpu_read_data;
    step(1, 0, 8'h01, 32'h0, 4'h0, 0, 32'h0);
    hi = 0;
    for (int i = 0; i < 20 && !cpu_done; i++) begin
      step_idle();
      if (mem_read_en) hi++;
    end
    check("to_wait_cycles", hi, TB_TO);
    check("to_done", cpu_done, 1);
    check("to_error", cpu_error, 1);
    check("to_rdata_kept", cpu_read_data, saved);
    step_idle();
    // Response on the expiry edge completes normally.
    step(1, 0, 8'h02, 32'h0, 4'h0, 0, 32'h0);
    repeat (TB_TO) step_idle();
    step(0, 0, 8'h00, 32'h0, 4'h0, 1, 32'hCAFE_F00D);
    check("exp_edge_done", cpu_done, 1);
    check("exp_edge_no_error", cpu_error, 0);
    check("exp_edge_data", cpu_read_data, 32'hCAFE_F00D);
    step_idle();
`endif

    // Reset in the middle of WAIT.
    step(1, 0, 8'h2A, 32'h0, 4'h0, 0, 32'h0);
    step_idle();
    step_idle();
    #1 reset = 1'b1;
    #1;
    check("mid_rst_busy", cpu_busy, 0);
    check("mid_rst_rd_en", mem_read_en, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_rdata", cpu_read_data, 0);
    model_reset();
    compute_exp();
    step_idle();
    step_idle();
    reset = 1'b0;
    step(0, 0, 8'h00, 32'h0, 4'h0, 1, 32'hFFFF_FFFF);
    check("post_rst_resp_done", cpu_done, 0);
    step_idle();
    check("post_rst_resp_done2", cpu_done, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic rd, wr, resp, in_wait, in_req;
      rd = ($urandom_range(0, 3) == 0);
      wr = ($urandom_range(0, 3) == 0);
      in_req  = (t_acc >= 0) && (t_end < 0) && (k == t_acc + 1);
      in_wait = (t_acc >= 0) && (t_end < 0) && (k >= t_acc + 2);
      if (in_wait) resp = ($urandom_range(0, 2) == 0);
      else if (in_req) resp = 1'b0;
      else resp = ($urandom_range(0, 7) == 0);
      step(rd, wr, 8'($urandom), $urandom, 4'($urandom), resp, $urandom);
    end
    repeat (3) step_idle();

    // 16-bit instance: two-byte words, low half of the memory data.
    n_addr = 8'h07; n_rd = 1'b1;
    step_idle();
    n_rd = 1'b0;
    step_idle();
    check("nar_addr", n_maddr, 32'h0E);
    check("nar_rd_en", n_mrd, 1);
    n_mrv = 32'h1234_ABCD; n_resp = 1'b1;
    step_idle();
    n_resp = 1'b0;
    check("nar_done", n_done, 1);
    check("nar_data", n_rdata, 16'hABCD);
    step_idle();
    check("nar_idle", n_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
